// File: rtl/map_pkg.sv
// map_pkg: shared constants and the sequencer state type for the tile-map
// collision path.
//   TILE_SZ, MAP_COLS, MAP_ROWS : tile map geometry
//   SCREEN_W, SCREEN_H          : visible pixel area (map extent in pixels)
//   seq_state_t                 : sequencer states
package map_pkg;

  localparam int TILE_SZ  = 16;
  localparam int MAP_COLS = 40;
  localparam int MAP_ROWS = 30;
  localparam int SCREEN_W = MAP_COLS * TILE_SZ;
  localparam int SCREEN_H = MAP_ROWS * TILE_SZ;

  typedef enum logic [2:0] {
    IDLE,
    PROBE0,
    PROBE1,
    PROBE2,
    PROBE3,
    RESP
  } seq_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
// Returns a one-hot grant for the first asserted request found when searching
// upward from ptr+1 with wrap-around, so the last winner has lowest priority.
//   req   [NUM_REQ-1:0]          in  request vector
//   ptr   [$clog2(NUM_REQ)-1:0]  in  index of the previous winner
//   grant [NUM_REQ-1:0]          out one-hot grant, all-zero when req == 0
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant
);

  localparam int PW = $clog2(NUM_REQ);

  int             sum;
  logic [PW-1:0]  idx;
  logic           found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = 0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      sum = int'(ptr) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = PW'(sum);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/map_collision_sequencer.sv
// map_collision_sequencer: shares the single combinational wall-lookup port
// of the tile map between NUM_REQ movers. An accepted request is the top-left
// pixel of a SPRITE_SZ x SPRITE_SZ sprite; the four corners are probed one per
// cycle and the OR of the wall bits is returned to the owner.
//
// Optional feature (macro MAP_QUERY_BOUNDS_EN): corners falling outside the
// screen count as blocked and are probed at the clamped edge coordinate.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   req_valid     per-requester strobe, held until accepted
//   req_x, req_y  packed candidate coordinates (slice i = requester i)
//   req_ready     one-hot grant, only in IDLE
//   resp_valid    one-cycle pulse to the owner of the result
//   resp_blocked  result bit, qualified by resp_valid
//   map_x, map_y  registered probe coordinate to the map
//   map_is_wall   combinational wall bit for (map_x, map_y)
module map_collision_sequencer
  import map_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int SPRITE_SZ = 16,
  parameter int X_W       = 10,
  parameter int Y_W       = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*X_W-1:0] req_x,
  input  logic [NUM_REQ*Y_W-1:0] req_y,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic                   resp_blocked,
  output logic [X_W-1:0]         map_x,
  output logic [Y_W-1:0]         map_y,
  input  logic                   map_is_wall
);

  localparam int             PW      = $clog2(NUM_REQ);
  localparam logic [PW-1:0]  PTR_RST = PW'(NUM_REQ - 1);

  seq_state_t     state_q, state_d;
  logic [PW-1:0]  rr_ptr;
  logic [PW-1:0]  owner;
  logic [X_W-1:0] base_x;
  logic [Y_W-1:0] base_y;
  logic           acc;

  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]      grant_id;
  logic [X_W-1:0]     sel_x;
  logic [Y_W-1:0]     sel_y;
  logic               accept;
  logic               probing;
  logic               load;
  logic [1:0]         corner_sel;
  logic [X_W-1:0]     src_x;
  logic [Y_W-1:0]     src_y;
  logic [X_W-1:0]     probe_x;
  logic [Y_W-1:0]     probe_y;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Owner index and coordinates of the granted requester.
  always_comb begin
    grant_id = '0;
    sel_x    = '0;
    sel_y    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_id = PW'(i);
        sel_x    = req_x[i*X_W +: X_W];
        sel_y    = req_y[i*Y_W +: Y_W];
      end
    end
  end

  // Next state, corner to load into the probe registers, and outputs.
  always_comb begin
    state_d      = state_q;
    load         = 1'b0;
    corner_sel   = 2'd0;
    src_x        = base_x;
    src_y        = base_y;
    accept       = 1'b0;
    probing      = 1'b0;
    req_ready    = '0;
    resp_valid   = '0;
    resp_blocked = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = grant;
        if (|grant) begin
          accept  = 1'b1;
          load    = 1'b1;
          src_x   = sel_x;
          src_y   = sel_y;
          state_d = PROBE0;
        end
      end
      PROBE0: begin
        probing    = 1'b1;
        load       = 1'b1;
        corner_sel = 2'd1;
        state_d    = PROBE1;
      end
      PROBE1: begin
        probing    = 1'b1;
        load       = 1'b1;
        corner_sel = 2'd2;
        state_d    = PROBE2;
      end
      PROBE2: begin
        probing    = 1'b1;
        load       = 1'b1;
        corner_sel = 2'd3;
        state_d    = PROBE3;
      end
      PROBE3: begin
        probing = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        resp_valid[owner] = 1'b1;
        resp_blocked      = acc;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Corner coordinate: bit 0 of corner_sel adds the x offset, bit 1 the y offset.
`ifdef MAP_QUERY_BOUNDS_EN
  localparam int              XW1   = X_W + 1;
  localparam int              YW1   = Y_W + 1;
  localparam logic [X_W:0]    OFS_X = XW1'(SPRITE_SZ - 1);
  localparam logic [Y_W:0]    OFS_Y = YW1'(SPRITE_SZ - 1);
  localparam logic [X_W:0]    LIM_X = XW1'(SCREEN_W);
  localparam logic [Y_W:0]    LIM_Y = YW1'(SCREEN_H);
  localparam logic [X_W-1:0]  MAX_X = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0]  MAX_Y = Y_W'(SCREEN_H - 1);

  logic [X_W:0] sum_x;
  logic [Y_W:0] sum_y;
  logic         oob_x, oob_y;
  logic         corner_oob;
  logic         oob_q;

  always_comb begin
    sum_x      = {1'b0, src_x} + (corner_sel[0] ? OFS_X : '0);
    sum_y      = {1'b0, src_y} + (corner_sel[1] ? OFS_Y : '0);
    oob_x      = (sum_x >= LIM_X);
    oob_y      = (sum_y >= LIM_Y);
    corner_oob = oob_x | oob_y;
    probe_x    = oob_x ? MAX_X : sum_x[X_W-1:0];
    probe_y    = oob_y ? MAX_Y : sum_y[Y_W-1:0];
  end
`else
  localparam logic [X_W-1:0] OFS_X = X_W'(SPRITE_SZ - 1);
  localparam logic [Y_W-1:0] OFS_Y = Y_W'(SPRITE_SZ - 1);

  // Carry out of the top bit is dropped: coordinates wrap.
  always_comb begin
    probe_x = src_x + (corner_sel[0] ? OFS_X : '0);
    probe_y = src_y + (corner_sel[1] ? OFS_Y : '0);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_ptr  <= PTR_RST;
      owner   <= '0;
      base_x  <= '0;
      base_y  <= '0;
      acc     <= 1'b0;
      map_x   <= '0;
      map_y   <= '0;
`ifdef MAP_QUERY_BOUNDS_EN
      oob_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner  <= grant_id;
        rr_ptr <= grant_id;
        base_x <= sel_x;
        base_y <= sel_y;
        acc    <= 1'b0;
      end else if (probing) begin
`ifdef MAP_QUERY_BOUNDS_EN
        acc <= acc | map_is_wall | oob_q;
`else
        acc <= acc | map_is_wall;
`endif
      end
      if (load) begin
        map_x <= probe_x;
        map_y <= probe_y;
`ifdef MAP_QUERY_BOUNDS_EN
        oob_q <= corner_oob;
`endif
      end
    end
  end

endmodule

// File: tb/tb_map_collision_sequencer.sv
// Bench for map_collision_sequencer (default build, bounds feature off).
// A transaction-level model predicts every output on every falling edge; the
// directed sequence adds literal expectations for coordinates, latency,
// round-robin order and reset behaviour.
module tb_map_collision_sequencer;

  localparam int N  = 4;
  localparam int XW = 10;
  localparam int YW = 9;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*XW-1:0] req_x;
  logic [N*YW-1:0] req_y;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic            resp_blocked;
  logic [XW-1:0]   map_x;
  logic [YW-1:0]   map_y;
  logic            map_is_wall;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  map_collision_sequencer #(
    .NUM_REQ(N), .SPRITE_SZ(16), .X_W(XW), .Y_W(YW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_x        (req_x),
    .req_y        (req_y),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_blocked (resp_blocked),
    .map_x        (map_x),
    .map_y        (map_y),
    .map_is_wall  (map_is_wall)
  );

  // Map: tile column 0 is wall, plus the single tile (col 20, row 5).
  function automatic logic wall_at(input int x, input int y);
    int col;
    int row;
    col = x / 16;
    row = y / 16;
    return (col == 0) || (col == 20 && row == 5);
  endfunction

  assign map_is_wall = wall_at(int'(map_x), int'(map_y));

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int corner_x(input int x, input int k);
    return (x + ((k % 2) != 0 ? 15 : 0)) % 1024;
  endfunction

  function automatic int corner_y(input int y, input int k);
    return (y + ((k / 2) != 0 ? 15 : 0)) % 512;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int i = 1; i <= N; i++) begin
      if (v[(last + i) % N]) return (last + i) % N;
    end
    return -1;
  endfunction

  // Model: m_phase counts cycles since acceptance (0 = free, 5 = response).
  int m_phase = 0;
  int m_owner = 0;
  int m_x     = 0;
  int m_y     = 0;
  int m_blk   = 0;
  int m_last  = N - 1;
  int m_mx    = 0;
  int m_my    = 0;
  int glog_idx[$];
  int glog_cyc[$];

  always @(negedge clk) begin
    int           pick;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rv;
    if (!rst_n) begin
      m_phase = 0;
      m_blk   = 0;
      m_last  = N - 1;
      m_mx    = 0;
      m_my    = 0;
    end
    pick      = (m_phase == 0) ? rr_pick(req_valid, m_last) : -1;
    exp_ready = '0;
    if (pick >= 0) exp_ready[pick] = 1'b1;
    exp_rv = '0;
    if (m_phase == 5) exp_rv[m_owner] = 1'b1;
    check("req_ready",    int'(req_ready),    int'(exp_ready));
    check("resp_valid",   int'(resp_valid),   int'(exp_rv));
    check("resp_blocked", int'(resp_blocked), (m_phase == 5) ? m_blk : 0);
    check("map_x",        int'(map_x),        m_mx);
    check("map_y",        int'(map_y),        m_my);
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] && req_valid[i]) begin
        glog_idx.push_back(i);
        glog_cyc.push_back(cyc);
      end
    end
    if (rst_n) begin
      case (m_phase)
        0: if (pick >= 0) begin
          m_owner = pick;
          m_last  = pick;
          m_x     = int'(req_x[pick*XW +: XW]);
          m_y     = int'(req_y[pick*YW +: YW]);
          m_blk   = 0;
          for (int k = 0; k < 4; k++)
            if (wall_at(corner_x(m_x, k), corner_y(m_y, k))) m_blk = 1;
          m_mx    = corner_x(m_x, 0);
          m_my    = corner_y(m_y, 0);
          m_phase = 1;
        end
        1, 2, 3: begin
          m_mx    = corner_x(m_x, m_phase);
          m_my    = corner_y(m_y, m_phase);
          m_phase = m_phase + 1;
        end
        4:       m_phase = 5;
        default: m_phase = 0;
      endcase
    end
  end

  int seen_x[4];
  int seen_y[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_req(input int id, input int x, input int y, input int exp_blk);
    int waited;
    waited = 0;
    req_x[id*XW +: XW] = XW'(x);
    req_y[id*YW +: YW] = YW'(y);
    req_valid[id] = 1'b1;
    #1;
    while (!req_ready[id] && waited < 50) begin
      tick();
      waited++;
    end
    check("grant_timeout", int'(waited < 50), 1);
    tick();
    req_valid[id] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      seen_x[k] = int'(map_x);
      seen_y[k] = int'(map_y);
      check("ready_busy", int'(req_ready), 0);
      tick();
    end
    check("resp_onehot",  int'(resp_valid), 1 << id);
    check("resp_result",  int'(resp_blocked), exp_blk);
    check("ready_resp",   int'(req_ready), 0);
    tick();
    check("resp_width",   int'(resp_valid), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", int'(req_ready), 0);
    check("rst_resp",  int'(resp_valid), 0);
    check("rst_mapx",  int'(map_x), 0);
    check("rst_mapy",  int'(map_y), 0);
    rst_n = 1'b1;

    // Open area.
    run_req(0, 32, 32, 0);
    check("open_x0", seen_x[0], 32);
    check("open_x1", seen_x[1], 47);
    check("open_x2", seen_x[2], 32);
    check("open_x3", seen_x[3], 47);
    check("open_y0", seen_y[0], 32);
    check("open_y1", seen_y[1], 32);
    check("open_y2", seen_y[2], 47);
    check("open_y3", seen_y[3], 47);

    // Left corners in wall column 0.
    run_req(1, 8, 16, 1);

    // Only the bottom-right corner touches tile (20,5).
    run_req(2, 310, 70, 1);
    check("c3_x", seen_x[3], 325);
    check("c3_y", seen_y[3], 85);

    // Off-screen corners probed raw.
    run_req(3, 630, 470, 0);
    check("edge_x1", seen_x[1], 645);
    check("edge_y3", seen_y[3], 485);

    // Wrap: x+15 = 1030 -> 6 (wall column 0), y+15 = 515 -> 3.
    run_req(0, 1015, 500, 1);
    check("wrap_x1", seen_x[1], 6);
    check("wrap_y2", seen_y[2], 3);

    // Reset in PROBE2 drops the request.
    req_x[2*XW +: XW] = 10'd100;
    req_y[2*YW +: YW] = 9'd100;
    req_valid[2] = 1'b1;
    #1;
    check("mid_grant", int'(req_ready), 4);
    tick();
    req_valid[2] = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_mapx",  int'(map_x), 0);
    check("mid_rst_mapy",  int'(map_y), 0);
    check("mid_rst_resp",  int'(resp_valid), 0);
    check("mid_rst_ready", int'(req_ready), 0);
    tick();
    tick();

    // Contention from reset release: expect 0,1,2,3,0 every 6 cycles.
    glog_idx.delete();
    glog_cyc.delete();
    req_valid = '1;
    rst_n     = 1'b1;
    #1;
    check("first_after_rst", int'(req_ready), 1);
    repeat (31) tick();
    check("glog_len", int'(glog_idx.size() >= 5), 1);
    for (int i = 0; i < 5; i++) begin
      if (glog_idx.size() > i) begin
        check("rr_order", glog_idx[i], i % 4);
        if (i > 0) check("rr_spacing", glog_cyc[i] - glog_cyc[i-1], 6);
      end
    end
    req_valid = '0;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
